// File: rtl/mcu_spi_master.sv
// Byte-oriented SPI mode-0 master for the MCU link: frames transfers with csn,
// shifts one byte per tx handshake and synchronises the slave interrupt line.
module mcu_spi_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_IDLE  = 4
) (
    input  logic       clk32,
    input  logic       reset,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       spi_sclk,
    output logic       spi_csn,
    output logic       spi_mosi,
    input  logic       spi_miso,
    input  logic       spi_intn,
    output logic       irq,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        SHIFT_LO  = 3'd2,
        SHIFT_HI  = 3'd3,
        WAIT_NEXT = 3'd4,
        HOLD      = 3'd5,
        GAP       = 3'd6
    } state_t;

    localparam logic [7:0] DIV_RELOAD   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_RELOAD = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_RELOAD  = 8'(CS_HOLD - 1);
    localparam logic [7:0] IDLE_RELOAD  = 8'(CS_IDLE - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [2:0] bit_q;
    logic [6:0] tx_sh_q;
    logic [6:0] rx_sh_q;
    logic       last_q;
    logic       sclk_q;
    logic       csn_q;
    logic       mosi_q;
    logic       rx_valid_q;
    logic [7:0] rx_data_q;
    logic [7:0] rx_byte_d;
    logic       sync1_q;
    logic       sync2_q;
    logic       accept;
    logic       cnt_done;

    // Handshake: a byte moves on the clk32 edge where tx_valid && tx_ready;
    // tx_ready depends only on state, never on tx_valid.
    assign tx_ready  = (state_q == IDLE) || (state_q == WAIT_NEXT);
    assign accept    = tx_valid && tx_ready;
    assign cnt_done  = (cnt_q == 8'd0);
    assign rx_byte_d = {rx_sh_q, spi_miso};

    assign busy      = (state_q != IDLE);
    assign spi_sclk  = sclk_q;
    assign spi_csn   = csn_q;
    assign spi_mosi  = mosi_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign irq       = ~sync2_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            bit_q      <= 3'd0;
            tx_sh_q    <= 7'd0;
            rx_sh_q    <= 7'd0;
            last_q     <= 1'b0;
            sclk_q     <= 1'b0;
            csn_q      <= 1'b1;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'd0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= SETUP;
                        cnt_q   <= SETUP_RELOAD;
                        csn_q   <= 1'b0;
                        mosi_q  <= tx_data[7];
                        tx_sh_q <= tx_data[6:0];
                        last_q  <= tx_last;
                        bit_q   <= 3'd7;
                    end
                end
                SETUP: begin
                    if (cnt_done) begin
                        state_q <= SHIFT_LO;
                        cnt_q   <= DIV_RELOAD;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                SHIFT_LO: begin
                    if (cnt_done) begin
                        state_q <= SHIFT_HI;
                        sclk_q  <= 1'b1;
                        cnt_q   <= DIV_RELOAD;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                SHIFT_HI: begin
                    // miso is sampled on the last high cycle, right before sclk falls
                    if (cnt_done) begin
                        sclk_q  <= 1'b0;
                        rx_sh_q <= rx_byte_d[6:0];
                        if (bit_q == 3'd0) begin
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_byte_d;
                            state_q    <= last_q ? HOLD : WAIT_NEXT;
                            cnt_q      <= HOLD_RELOAD;
                        end else begin
                            bit_q   <= bit_q - 3'd1;
                            mosi_q  <= tx_sh_q[6];
                            tx_sh_q <= {tx_sh_q[5:0], 1'b0};
                            state_q <= SHIFT_LO;
                            cnt_q   <= DIV_RELOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                WAIT_NEXT: begin
                    // csn is already low, so the next byte skips the setup delay
                    if (accept) begin
                        state_q <= SHIFT_LO;
                        cnt_q   <= DIV_RELOAD;
                        mosi_q  <= tx_data[7];
                        tx_sh_q <= tx_data[6:0];
                        last_q  <= tx_last;
                        bit_q   <= 3'd7;
                    end
                end
                HOLD: begin
                    if (cnt_done) begin
                        state_q <= GAP;
                        csn_q   <= 1'b1;
                        mosi_q  <= 1'b0;
                        cnt_q   <= IDLE_RELOAD;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                GAP: begin
                    if (cnt_done) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    csn_q   <= 1'b1;
                    sclk_q  <= 1'b0;
                end
            endcase
        end
    end

    // Interrupt synchroniser; flops idle high so irq is quiet out of reset.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= spi_intn;
            sync2_q <= sync1_q;
        end
    end

endmodule

// File: tb/tb_mcu_spi_master.sv
// Directed bench for mcu_spi_master: default-timing instance plus a fast
// instance (CLK_DIV=1, CS_SETUP=1), with a slave model and rx scoreboard.
module tb_mcu_spi_master;

  localparam int CS_HOLD = 2;
  localparam int CS_IDLE = 4;
  localparam int LAT     = 67;
  localparam int PERIOD  = 65;

  // ---------------- clock / reset ----------------
  logic clk32 = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk32 = ~clk32;
  always @(posedge clk32) cyc <= cyc + 1;

  // ---------------- default instance ----------------
  logic       tx_valid, tx_ready, tx_last, rx_valid, busy;
  logic [7:0] tx_data, rx_data;
  logic       spi_sclk, spi_csn, spi_mosi, spi_miso, spi_intn, irq;
  logic [2:0] dbg_state;

  mcu_spi_master u_dut (
    .clk32(clk32), .reset(reset),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .spi_sclk(spi_sclk), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_intn(spi_intn), .irq(irq), .dbg_state(dbg_state)
  );

  // ---------------- fast instance (loopback) ----------------
  logic       f_tx_valid, f_tx_ready, f_tx_last, f_rx_valid, f_busy;
  logic [7:0] f_tx_data, f_rx_data;
  logic       f_spi_sclk, f_spi_csn, f_spi_mosi, f_spi_miso, f_irq;
  logic [2:0] f_dbg_state;
  assign f_spi_miso = f_spi_mosi;

  mcu_spi_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(2), .CS_IDLE(4)) u_fast (
    .clk32(clk32), .reset(reset),
    .tx_valid(f_tx_valid), .tx_ready(f_tx_ready), .tx_data(f_tx_data), .tx_last(f_tx_last),
    .rx_valid(f_rx_valid), .rx_data(f_rx_data), .busy(f_busy),
    .spi_sclk(f_spi_sclk), .spi_csn(f_spi_csn), .spi_mosi(f_spi_mosi),
    .spi_miso(f_spi_miso), .spi_intn(spi_intn), .irq(f_irq), .dbg_state(f_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] f_cap_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model for the default instance ----------------
  logic       loopback;
  logic [7:0] slv_pat;
  logic [7:0] slv_sh = 8'h00;
  logic [7:0] slv_cap = 8'h00;
  int         slv_bits = 0;
  int         n_sclk_rise = 0;
  int         csn_rises = 0;
  int         rx_pulses = 0;

  assign spi_miso = loopback ? spi_mosi : slv_sh[7];

  always @(negedge spi_csn) begin
    slv_sh   = slv_pat;
    slv_bits = 0;
  end
  always @(posedge spi_csn) csn_rises++;
  always @(posedge spi_sclk) begin
    n_sclk_rise++;
    slv_cap = {slv_cap[6:0], spi_mosi};
    slv_bits++;
    if (slv_bits % 8 == 0) cap_q.push_back(slv_cap);
  end
  always @(negedge spi_sclk) begin
    if (!spi_csn) slv_sh = (slv_bits % 8 == 0) ? slv_pat : {slv_sh[6:0], 1'b0};
  end

  logic [7:0] f_cap = 8'h00;
  int         f_bits = 0;
  always @(posedge f_spi_sclk) begin
    f_cap = {f_cap[6:0], f_spi_mosi};
    f_bits++;
    if (f_bits % 8 == 0) f_cap_q.push_back(f_cap);
  end

  // rx monitor for the default instance: pops the expected queue
  always @(negedge clk32) begin
    if (rx_valid === 1'b1) begin
      rx_pulses++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL rx_unexpected: observed %0h expected no rx_valid", rx_data);
      end else begin
        check("rx_data", rx_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic pick(input int sel);
    case (sel)
      0:       return spi_csn;
      1:       return busy;
      2:       return tx_ready;
      3:       return irq;
      default: return rx_valid;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input logic v,
                          input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk32);
      if (pick(sel) === v) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed timeout after %0d cycles expected event", tag, budget);
    end
  endtask

  task automatic send_one(input logic [7:0] d, input logic last, output int t);
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    t        = cyc;
    @(negedge clk32);
    tx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int t0, r, r1, r2, r3, c_rise, b, acc, f_r1, f_r2, rx_snap, c, at, sum_irq;
  logic [15:0] patt;

  initial begin
    reset = 1'b1;
    tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    f_tx_valid = 1'b0; f_tx_data = 8'h00; f_tx_last = 1'b0;
    spi_intn = 1'b1; loopback = 1'b1; slv_pat = 8'h00;

    // reset values
    repeat (2) @(negedge clk32);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_pins", {spi_sclk, spi_csn, spi_mosi}, 3'b010);
    check("rst_rx", {rx_valid, rx_data}, 9'h000);
    check("rst_busy_irq", {busy, irq}, 2'b00);
    check("rst_state", dbg_state, 3'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk32);

    // 1: loopback single byte 0xA5, last
    n_sclk_rise = 0;
    exp_q.push_back(8'hA5);
    send_one(8'hA5, 1'b1, t0);
    check("t1_csn_low_t1", spi_csn, 1'b0);
    wait_for("t1_rx", 4, 1'b1, 200, r);
    check("t1_rx_latency", r - t0, LAT);
    check("t1_sclk_rises", n_sclk_rise, 8);
    wait_for("t1_csn_rise", 0, 1'b1, 20, c_rise);
    check("t1_csn_rise_time", c_rise - r, CS_HOLD);
    wait_for("t1_busy_fall", 1, 1'b0, 20, b);
    check("t1_busy_fall_time", b - c_rise, CS_IDLE);

    // 2: slave shifts 0x3C, 3-byte frame with tx_valid held
    loopback = 1'b0; slv_pat = 8'h3C; csn_rises = 0;
    cap_q.delete();
    repeat (3) exp_q.push_back(8'h3C);
    tx_data = 8'h01; tx_last = 1'b0; tx_valid = 1'b1; t0 = cyc;
    @(negedge clk32);
    tx_data = 8'h02;
    wait_for("t2_rx1", 4, 1'b1, 200, r1);
    check("t2_rx1_latency", r1 - t0, LAT);
    @(negedge clk32);
    tx_data = 8'h03; tx_last = 1'b1;
    wait_for("t2_rx2", 4, 1'b1, 200, r2);
    check("t2_rx_period_a", r2 - r1, PERIOD);
    @(negedge clk32);
    tx_valid = 1'b0; tx_last = 1'b0;
    wait_for("t2_rx3", 4, 1'b1, 200, r3);
    check("t2_rx_period_b", r3 - r2, PERIOD);
    check("t2_no_csn_rise", csn_rises, 0);
    check("t2_cap_count", cap_q.size(), 3);
    for (int i = 1; i <= 3; i++) begin
      if (cap_q.size() > 0) check("t2_mosi_byte", cap_q.pop_front(), i);
    end

    // 6: tx_valid during GAP waits for IDLE
    wait_for("t6_csn_rise", 0, 1'b1, 20, c_rise);
    check("t2_csn_rise_time", c_rise - r3, CS_HOLD);
    loopback = 1'b1;
    @(negedge clk32);
    exp_q.push_back(8'h55);
    tx_data = 8'h55; tx_last = 1'b1; tx_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      if (tx_ready === 1'b1) begin
        acc = cyc;
        break;
      end
      @(negedge clk32);
    end
    check("t6_accept_at_idle", acc - c_rise, CS_IDLE);
    @(negedge clk32);
    tx_valid = 1'b0;
    // csn high over the gap cycles plus the IDLE cycle that took the byte
    check("t6_csn_high_len", {spi_csn, 8'(cyc - c_rise)}, {1'b0, 8'(CS_IDLE + 1)});
    wait_for("t6_rx", 4, 1'b1, 200, r);
    check("t6_rx_latency", r - acc, LAT);
    wait_for("t6_idle", 1, 1'b0, 30, b);

    // 3: fast instance, 0xFF then 0x00 back to back
    @(negedge clk32);
    check("f_ready_idle", f_tx_ready, 1'b1);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    f_tx_data = 8'hFF; f_tx_last = 1'b0; f_tx_valid = 1'b1; t0 = cyc;
    patt = 16'h0; f_r1 = -1; f_r2 = -1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk32);
      if (i == 1) begin
        f_tx_data = 8'h00;
        f_tx_last = 1'b1;
      end
      if (i >= 2 && i <= 17) patt = {patt[14:0], f_spi_sclk};
      if (f_r1 >= 0 && cyc == f_r1 + 1) f_tx_valid = 1'b0;
      if (f_rx_valid === 1'b1) begin
        if (exp_q.size() > 0) check("f_rx_data", f_rx_data, exp_q.pop_front());
        if (f_r1 < 0) f_r1 = cyc;
        else f_r2 = cyc;
      end
    end
    check("f_rx1_latency", f_r1 - t0, 18);
    check("f_rx2_latency", f_r2 - t0, 35);
    check("f_sclk_pattern", patt, 16'h5555);
    check("f_cap_count", f_cap_q.size(), 2);
    if (f_cap_q.size() > 0) check("f_mosi_byte0", f_cap_q.pop_front(), 8'hFF);
    if (f_cap_q.size() > 0) check("f_mosi_byte1", f_cap_q.pop_front(), 8'h00);
    check("f_idle_after", f_busy, 1'b0);

    // 4: reset 20 cycles into a byte
    rx_snap = rx_pulses;
    send_one(8'h5A, 1'b1, t0);
    repeat (19) @(negedge clk32);
    check("t4_csn_before", spi_csn, 1'b0);
    reset = 1'b1;
    #1;
    check("t4_async_pins", {spi_csn, spi_sclk}, 2'b10);
    check("t4_async_ready", {tx_ready, busy}, 2'b10);
    repeat (2) @(negedge clk32);
    reset = 1'b0;
    repeat (80) @(negedge clk32);
    check("t4_no_rx", rx_pulses, rx_snap);
    exp_q.push_back(8'hC3);
    send_one(8'hC3, 1'b1, t0);
    wait_for("t4_rx", 4, 1'b1, 200, r);
    check("t4_rx_latency", r - t0, LAT);
    wait_for("t4_idle", 1, 1'b0, 30, b);

    // 5: irq synchroniser
    @(negedge clk32);
    c = cyc;
    spi_intn = 1'b0;
    @(negedge clk32);
    spi_intn = 1'b1;
    sum_irq = 0;
    repeat (6) begin
      @(negedge clk32);
      if (irq === 1'b1) sum_irq++;
    end
    check("t5_short_pulse_len", sum_irq, 1);
    @(negedge clk32);
    c = cyc;
    spi_intn = 1'b0;
    wait_for("t5_irq_rise", 3, 1'b1, 4, at);
    check("t5_irq_rise_lat", (at - c >= 2) && (at - c <= 3), 1'b1);
    while (cyc < c + 10) @(negedge clk32);
    c = cyc;
    spi_intn = 1'b1;
    wait_for("t5_irq_fall", 3, 1'b0, 4, at);
    check("t5_irq_fall_lat", (at - c >= 2) && (at - c <= 3), 1'b1);

    // mid-frame intn activity must not disturb the byte
    exp_q.push_back(8'h96);
    send_one(8'h96, 1'b1, t0);
    r = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk32);
      spi_intn = 1'($urandom_range(0, 1));
      if (rx_valid === 1'b1) begin
        r = cyc;
        break;
      end
    end
    spi_intn = 1'b1;
    check("t5_rx_latency", r - t0, LAT);
    wait_for("t5_idle", 1, 1'b0, 30, b);
    check("final_exp_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
